uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  Host-to-board UART receiver: 8N1 serial in, bytes out, ASCII commands decoded into
//  TDC control levels startWriting/startReading. Feeds top-level control that the TDC
//  capture path and the FIFO->uart_tx readout path consume. Replaces push-button control.
// PARAMETERS
//  CLKS_PER_BIT  868    clk cycles per UART bit (100 MHz / 115200); must be >= 8
//  CMD_WRITE     8'h57  'W': start TDC acquisition (writing)
//  CMD_READ      8'h52  'R': start FIFO readout (reading)
//  CMD_STOP      8'h53  'S': stop both
// PORTS
//  clk           in   1  single system clock (same domain as FIFO write side)
//  rst           in   1  synchronous, active-high reset
//  i_rx          in   1  asynchronous serial line, idle high
//  o_byte        out  8  last correctly framed byte, LSB = first data bit
//  o_byte_valid  out  1  1-cycle pulse, o_byte valid
//  o_frame_err   out  1  1-cycle pulse, stop bit sampled low
//  o_cmd_err     out  1  1-cycle pulse, valid byte matched no command
//  startWriting  out  1  level, acquisition enabled
//  startReading  out  1  level, readout enabled
// BEHAVIOUR
//  - Reset: all outputs 0; synchroniser flops 1; FSM IDLE; counters 0. Reset mid-frame
//    abandons the frame, no pulse emitted.
//  - i_rx through 2-flop synchroniser (rx_s); all decisions use rx_s (2-cycle input lag).
//  - FSM IDLE/START/DATA/STOP; cycle counter width $clog2(CLKS_PER_BIT), bit index 3 bits.
//    IDLE : armed only after rx_s seen high >= 1 cycle since last frame (break / stuck-low
//           line never retriggers); rx_s==0 while armed -> START, cnt=0.
//    START: at cnt==CLKS_PER_BIT/2-1 sample rx_s (mid start bit). 1 -> glitch, IDLE, no
//           pulse. 0 -> DATA, cnt=0, idx=0.
//    DATA : at cnt==CLKS_PER_BIT-1 sample rx_s into shift reg (LSB first), cnt=0; after
//           idx==7 sample -> STOP.
//    STOP : at cnt==CLKS_PER_BIT-1 sample rx_s. 1 -> o_byte loaded + o_byte_valid next
//           cycle. 0 -> o_frame_err next cycle, o_byte unchanged, no decode. Both -> IDLE
//           (disarmed until line high).
//  - Latency: o_byte_valid rises 1 clk after the stop-bit sample cycle.
//  - Decode (same cycle as o_byte_valid, registered):
//    CMD_WRITE -> startWriting=1, startReading=0; CMD_READ -> startReading=1,
//    startWriting=0; CMD_STOP -> both 0; other -> o_cmd_err pulse, levels unchanged.
//    Writing and reading are mutually exclusive: never both 1.
//  - Repeated identical command: levels unchanged, no error.
//  - Back-to-back frames (next start bit immediately after stop) received without loss.
// STRUCTURE
//  - Shared defines file (with DIG_OUT): `CMD_WRITE/`CMD_READ/`CMD_STOP byte codes, default
//    UART CLKS_PER_BIT; FSM state encodings as localparams in uart_rx.
//  - Sub-module uart_rx: synchroniser + bit FSM -> o_byte/o_byte_valid/o_frame_err (mirror of
//    uart_tx). uart_cmd_rx = uart_rx + command decoder/level registers.
// TESTING (CLKS_PER_BIT=16, bench UART model drives i_rx)
//  1 Send 8'hA5 -> o_byte=8'hA5, one o_byte_valid, o_cmd_err pulse, levels 0/0.
//  2 'W' then 'R' then 'S' -> (W,R)=(1,0), then (0,1), then (0,0); valid pulse each.
//  3 Frame 8'h57 with stop bit 0 -> o_frame_err pulse, no valid, startWriting stays 0;
//    hold line low 40 bit times then 'R' -> no spurious frames, startReading=1.
//  4 Low glitch of 5 cycles on idle line -> no pulse of any kind, FSM back in IDLE.
//  5 rst asserted mid-DATA of 'W', released, then 'R' sent -> no pulse for 'W', R=1, W=0.
//  6 Ten back-to-back 'W'/'R' bytes, baud +/-3% -> all decoded, latency 1 clk after stop
//    sample, startWriting & startReading never both 1 (assertion).

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// uart_cmd_rx_pkg: shared UART defaults, command byte codes and receiver state encoding
package uart_cmd_rx_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 868;

    localparam logic [7:0] UART_CMD_WRITE = 8'h57;
    localparam logic [7:0] UART_CMD_READ  = 8'h52;
    localparam logic [7:0] UART_CMD_STOP  = 8'h53;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and break rejection
module uart_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_stop_ok,
    output logic [7:0] o_shift
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_t st, nx;
    logic rx_m, rx_s, armed;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] sh;
    logic half, full, cnt_clr, shift_en, stop_bad;

    assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign full = cnt == CW'(CLKS_PER_BIT - 1);
    assign o_shift = sh;

    always_ff @(posedge clk) begin
        st <= rst ? S_IDLE : nx;
    end

    always_comb begin
        nx = st;
        case (st)
            S_IDLE:  nx = (armed && !rx_s) ? S_START : S_IDLE;
            S_START: nx = half ? (rx_s ? S_IDLE : S_DATA) : S_START;
            S_DATA:  nx = (full && idx == 3'd7) ? S_STOP : S_DATA;
            S_STOP:  nx = full ? S_IDLE : S_STOP;
            default: nx = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr   = (st == S_IDLE) || (st == S_START ? half : full);
        shift_en  = st == S_DATA && full;
        o_stop_ok = st == S_STOP && full && rx_s;
        stop_bad  = st == S_STOP && full && !rx_s;
    end

    // armed drops whenever a frame is in progress, so a line stuck low after a frame never retriggers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            armed        <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            rx_m         <= i_rx;
            rx_s         <= rx_m;
            armed        <= st == S_IDLE && (armed || rx_s);
            cnt          <= cnt_clr ? '0 : cnt + 1'b1;
            idx          <= st != S_DATA ? 3'd0 : idx + 3'(shift_en);
            sh           <= shift_en ? {rx_s, sh[7:1]} : sh;
            o_byte       <= o_stop_ok ? sh : o_byte;
            o_byte_valid <= o_stop_ok;
            o_frame_err  <= stop_bad;
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver plus ASCII command decoder driving exclusive TDC write/read levels
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter logic [7:0]  CMD_WRITE    = UART_CMD_WRITE,
    parameter logic [7:0]  CMD_READ     = UART_CMD_READ,
    parameter logic [7:0]  CMD_STOP     = UART_CMD_STOP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_cmd_err,
    output logic       startWriting,
    output logic       startReading
);

    logic stop_ok, hit_w, hit_r, hit_s;
    logic [7:0] shift;
    logic [1:0] lv, lv_nx;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (i_rx),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .o_frame_err  (o_frame_err),
        .o_stop_ok    (stop_ok),
        .o_shift      (shift)
    );

    // decode from the stop-sample strobe so levels change in the same cycle o_byte_valid rises
    always_comb begin
        hit_w = shift == CMD_WRITE;
        hit_r = shift == CMD_READ;
        hit_s = shift == CMD_STOP;
        lv_nx = !stop_ok ? lv : hit_w ? 2'b10 : hit_r ? 2'b01 : hit_s ? 2'b00 : lv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lv        <= 2'b00;
            o_cmd_err <= 1'b0;
        end else begin
            lv        <= lv_nx;
            o_cmd_err <= stop_ok && !(hit_w || hit_r || hit_s);
        end
    end

    assign startWriting = lv[1];
    assign startReading = lv[0];

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: UART line model with scoreboard of expected receiver pulses and command levels
module tb_uart_cmd_rx;

    localparam int CPB   = 16;
    localparam int TCLK  = 100;
    localparam int BIT_N = CPB * TCLK;
    localparam int BIT_F = 1552;
    localparam int BIT_S = 1648;
    localparam int LAT   = 155;

    typedef struct {
        bit         ferr;
        logic [7:0] b;
        bit         w;
        bit         r;
        bit         cerr;
        int         t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_rx = 1'b1;
    logic [7:0] o_byte;
    logic o_byte_valid, o_frame_err, o_cmd_err, startWriting, startReading;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit both_seen = 1'b0;
    bit m_w = 1'b0, m_r = 1'b0;
    logic [7:0] last_b = 8'h00;
    exp_t q[$];

    uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (i_rx),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .o_frame_err  (o_frame_err),
        .o_cmd_err    (o_cmd_err),
        .startWriting (startWriting),
        .startReading (startReading)
    );

    always #(TCLK / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b, input int bit_t, input bit stop_ok, input bit push);
        exp_t e;
        if (push) begin
            e.ferr = !stop_ok;
            e.cerr = 1'b0;
            e.t0   = cyc;
            if (stop_ok) begin
                last_b = b;
                if (b == 8'h57) begin m_w = 1'b1; m_r = 1'b0; end
                else if (b == 8'h52) begin m_w = 1'b0; m_r = 1'b1; end
                else if (b == 8'h53) begin m_w = 1'b0; m_r = 1'b0; end
                else e.cerr = 1'b1;
            end
            e.b = last_b;
            e.w = m_w;
            e.r = m_r;
            q.push_back(e);
        end
        i_rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            #(bit_t);
        end
        i_rx = stop_ok;
        #(bit_t);
    endtask

    task automatic idle(input int bits);
        i_rx = 1'b1;
        #(bits * BIT_N);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (startWriting && startReading) both_seen = 1'b1;
        assert (!(startWriting && startReading)) else both_seen = 1'b1;
        if (o_byte_valid || o_frame_err || o_cmd_err) begin
            if (q.size() == 0) chk("spurious", {o_byte_valid, o_frame_err, o_cmd_err}, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("valid", o_byte_valid, !e.ferr);
                chk("ferr", o_frame_err, e.ferr);
                chk("cerr", o_cmd_err, e.cerr);
                chk("byte", o_byte, e.b);
                chk("lvl", {startWriting, startReading}, {e.w, e.r});
                chk("lat", cyc - e.t0, LAT);
            end
        end
    end

    initial begin
        #(200000 * TCLK);
        $display("FAIL watchdog q=%0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("rst_out", {o_byte, o_byte_valid, o_frame_err, o_cmd_err, startWriting, startReading}, 0);
        idle(2);
        send(8'hA5, BIT_N, 1'b1, 1'b1);
        drain();
        chk("a5_lvl", {startWriting, startReading}, 2'b00);
        send(8'h57, BIT_N, 1'b1, 1'b1);
        send(8'h52, BIT_N, 1'b1, 1'b1);
        send(8'h53, BIT_N, 1'b1, 1'b1);
        drain();
        chk("wrs_lvl", {startWriting, startReading}, 2'b00);
        send(8'h57, BIT_N, 1'b0, 1'b1);
        i_rx = 1'b0;
        #(40 * BIT_N);
        idle(2);
        chk("ferr_w", startWriting, 1'b0);
        send(8'h52, BIT_N, 1'b1, 1'b1);
        drain();
        chk("after_brk", {startWriting, startReading}, 2'b01);
        idle(2);
        @(negedge clk);
        i_rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(3);
        chk("glitch_q", q.size(), 0);
        send(8'h53, BIT_N, 1'b1, 1'b1);
        drain();
        chk("glitch_s", {startWriting, startReading}, 2'b00);
        send(8'h57, BIT_N, 1'b1, 1'b1);
        drain();
        fork
            send(8'h57, BIT_N, 1'b1, 1'b0);
            begin
                #(3 * BIT_N);
                rst = 1'b1;
                m_w = 1'b0;
                m_r = 1'b0;
                last_b = 8'h00;
                #(8 * BIT_N);
                rst = 1'b0;
            end
        join
        @(negedge clk);
        chk("rst_mid", {o_byte, o_byte_valid, o_frame_err, o_cmd_err, startWriting, startReading}, 0);
        idle(2);
        send(8'h52, BIT_N, 1'b1, 1'b1);
        drain();
        chk("rst_r", {startWriting, startReading}, 2'b01);
        for (int i = 0; i < 10; i++)
            send(i[0] ? 8'h52 : 8'h57, i[1] ? BIT_S : BIT_F, 1'b1, 1'b1);
        drain();
        chk("b2b_lvl", {startWriting, startReading}, 2'b01);
        chk("excl", both_seen, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
